mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported 64-bit core memory between the instruction-fetch requester and the load/store requester. Each requester uses a valid/ready request channel and a valid/ready response channel. The block grants at most one request per cycle using round-robin priority and drives the memory's combinational-read / clocked-write port. It captures each response into a one-entry holding slot per requester. It sits between the pipeline's fetch/memory stages and the RAM.

## Interface
Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, memory data width; mask width is DATA_W/8

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request present
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  ADDR_W  fetch address (pc)
- i_resp_valid  out  1  fetch response held
- i_resp_ready  in  1  fetch response consumed
- i_resp_instr  out  32  instruction, m_resp[31:0] at the grant cycle
- i_resp_exc  out  1  m_exc at the grant cycle
- d_req_valid  in  1  data request present
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data address
- d_req_data  in  DATA_W  store data
- d_req_wren  in  1  1 = store, 0 = load
- d_req_mask  in  DATA_W/8  store byte enables
- d_resp_valid  out  1  data response held
- d_resp_ready  in  1  data response consumed
- d_resp_data  out  DATA_W  load data; 0 for stores
- d_resp_exc  out  1  m_exc at the grant cycle
- m_addr  out  ADDR_W  memory address
- m_data  out  DATA_W  memory write data
- m_wren  out  1  memory write enable, committed at posedge
- m_mask  out  DATA_W/8  memory byte enables
- m_resp  in  DATA_W  combinational read data for m_addr
- m_exc  in  1  combinational address-out-of-range flag for m_addr

## Operation
- Eligibility:
  - Requester X is eligible when X_req_valid is 1 and its slot is either empty or draining this cycle (X_resp_valid & X_resp_ready).
- Grant:
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one named by priority pointer `prio` is granted.
  - At most one grant per cycle. X_req_ready = grant to X.
- Pointer:
  - After a grant to X, `prio` moves to the other requester.
  - With no grant, `prio` holds.
- Memory drive:
  - m_addr, m_data and m_mask come from the granted request.
  - With no grant, m_addr = i_req_addr and m_data = 0, m_mask = 0.
  - m_wren = grant_d & d_req_wren & ~m_exc. An out-of-range store never writes.
- Capture at the grant edge:
  - The granted slot loads response data and m_exc, and sets valid.
  - Fetch data is m_resp[31:0].
  - Load data is m_resp. Store data is 0.
- Slot release:
  - A slot clears when X_resp_ready & X_resp_valid and there is no new grant to X.
  - A simultaneous drain and new grant reloads the slot, so valid stays 1.
- Responses return in order per requester. No cross-requester ordering is implied.

## Timing
- Reset values: i_resp_valid, d_resp_valid, i_resp_instr, d_resp_data, i_resp_exc, d_resp_exc, i_req_ready, d_req_ready, m_wren all 0; `prio` = instruction.
- Latency: grant at edge N, response valid from N+1. The store is committed by the memory at edge N.
- Throughput: one request per cycle total. A requester whose consumer holds ready=1 is serviced every cycle when uncontested, and every other cycle when contested.
- Backpressure: while a slot is full and not draining, that requester gets no grant and the other requester may use every cycle.
- Ready never depends on the same requester's req_valid beyond the grant decision, so no combinational loop.
- Reset asserted mid-operation: slots are dropped and `prio` is reset. req_ready and m_wren are 0 while rst is high, so no write occurs.

## Structure
- Package `mem_arb_pkg`:
  - `req_id_t` enum {REQ_I, REQ_D}
  - INSTR_W = 32
- Sub-module `resp_slot`: one-entry valid/ready holding register, parameterized by payload width, with load/drain/simultaneous semantics. Instantiated once per requester.
- Top level holds the grant logic, the `prio` register and the memory muxing.

## Test plan
- Fetch only: i_req addr 0x0 for 4 consecutive cycles, i_resp_ready=1 -> i_req_ready every cycle, 4 responses at N+1…N+4, each equal to memory bytes 0..3, exc=0.
- Contention: both valid every cycle, both resp_ready=1 -> grants alternate I,D,I,D starting with I after reset.
- Store then load: store 0xDEADBEEF_01234567 to 0x1000_0008 with mask 0x0F, then load the same address -> load returns 0x????????_01234567 with the upper bytes unchanged.
- Out-of-range store: addr 0x0000_0000_0010_0000, wren=1 -> m_wren=0, d_resp_exc=1, d_resp_data=0, memory unchanged.
- Backpressure: d_resp_ready=0 holding one data response while both request -> d_req_ready stays 0, fetch granted every cycle. Raising d_resp_ready for one cycle allows the next D grant in that same cycle.
- Reset mid-flight: assert rst in the cycle after a store grant with the slot still held -> d_resp_valid=0 immediately, no further m_wren, `prio` = instruction after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core memory port arbiter.
//   req_id_t : identifies a requester (instruction fetch or load/store)
//   INSTR_W  : width of a fetched instruction
package mem_arb_pkg;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int INSTR_W = 32;

endpackage

// File: rtl/mem_port_arbiter_resp_slot.sv
// resp_slot: one-entry valid/ready holding register for a memory response.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_data this cycle (a new grant)
//   load_data  : payload to capture
//   valid      : slot holds a response
//   ready      : consumer takes the held response this cycle
//   data       : held payload
// A load in the same cycle as a drain replaces the entry, so valid stays 1.
module resp_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            // NOTE: the payload is reset too because it is visible on the
            // response ports and must read 0 after reset, not just be masked
            // by valid.
            data  <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported core memory between the
// instruction-fetch requester (i_*) and the load/store requester (d_*).
//   clk, rst        : clock, asynchronous active-high reset
//   i_req_*         : fetch request channel (valid/ready, addr)
//   i_resp_*        : fetch response channel (valid/ready, instr, exc)
//   d_req_*         : data request channel (valid/ready, addr, data, wren, mask)
//   d_resp_*        : data response channel (valid/ready, data, exc)
//   m_*             : memory port; read data and exc are combinational for
//                     m_addr, writes commit at posedge when m_wren is high
// One grant per cycle, round-robin between the two requesters; each response
// is captured at the grant edge into that requester's holding slot.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_resp_valid,
    input  logic                i_resp_ready,
    output logic [INSTR_W-1:0]  i_resp_instr,
    output logic                i_resp_exc,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_data,
    input  logic                d_req_wren,
    input  logic [DATA_W/8-1:0] d_req_mask,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                d_resp_exc,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_wren,
    output logic [DATA_W/8-1:0] m_mask,
    input  logic [DATA_W-1:0]   m_resp,
    input  logic                m_exc
);

    req_id_t prio;
    req_id_t prio_next;
    logic    elig_i;
    logic    elig_d;
    logic    grant_i;
    logic    grant_d;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        elig_i    = 1'b0;
        elig_d    = 1'b0;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        prio_next = prio;

        // A slot that drains this cycle can accept the next response at once.
        elig_i = i_req_valid & (~i_resp_valid | i_resp_ready);
        elig_d = d_req_valid & (~d_resp_valid | d_resp_ready);

        // Grants are suppressed during reset so no write can reach memory.
        if (!rst) begin
            grant_i = elig_i & (~elig_d | (prio == REQ_I));
            grant_d = elig_d & (~elig_i | (prio == REQ_D));
        end

        if (grant_i) begin
            prio_next = REQ_D;
        end else if (grant_d) begin
            prio_next = REQ_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= REQ_I;
        end else begin
            prio <= prio_next;
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // The idle cycle still presents the fetch address so the read path stays
    // quiet on the data bus and mask.
    always_comb begin
        m_addr = i_req_addr;
        m_data = '0;
        m_mask = '0;
        if (grant_d) begin
            m_addr = d_req_addr;
            m_data = d_req_data;
            m_mask = d_req_mask;
        end
    end

    assign m_wren = grant_d & d_req_wren & ~m_exc;

    logic [INSTR_W:0] i_load_data;
    logic [INSTR_W:0] i_slot_data;
    logic [DATA_W:0]  d_load_data;
    logic [DATA_W:0]  d_slot_data;

    assign i_load_data = {m_exc, m_resp[INSTR_W-1:0]};
    assign d_load_data = {m_exc, (d_req_wren ? {DATA_W{1'b0}} : m_resp)};

    resp_slot #(.W(INSTR_W + 1)) u_i_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_i),
        .load_data (i_load_data),
        .valid     (i_resp_valid),
        .ready     (i_resp_ready),
        .data      (i_slot_data)
    );

    resp_slot #(.W(DATA_W + 1)) u_d_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_d),
        .load_data (d_load_data),
        .valid     (d_resp_valid),
        .ready     (d_resp_ready),
        .data      (d_slot_data)
    );

    assign i_resp_exc   = i_slot_data[INSTR_W];
    assign i_resp_instr = i_slot_data[INSTR_W-1:0];
    assign d_resp_exc   = d_slot_data[DATA_W];
    assign d_resp_data  = d_slot_data[DATA_W-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a sparse RAM environment driven by the DUT,
// a reference model of the arbitration rules with its own memory image, and a
// scoreboard monitor that checks every response handshake.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [63:0] i_req_addr;
    logic        i_resp_valid;
    logic        i_resp_ready;
    logic [31:0] i_resp_instr;
    logic        i_resp_exc;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [63:0] d_req_addr;
    logic [63:0] d_req_data;
    logic        d_req_wren;
    logic [7:0]  d_req_mask;
    logic        d_resp_valid;
    logic        d_resp_ready;
    logic [63:0] d_resp_data;
    logic        d_resp_exc;
    logic [63:0] m_addr;
    logic [63:0] m_data;
    logic        m_wren;
    logic [7:0]  m_mask;
    logic [63:0] m_resp;
    logic        m_exc;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_ready (i_resp_ready),
        .i_resp_instr (i_resp_instr),
        .i_resp_exc   (i_resp_exc),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_data   (d_req_data),
        .d_req_wren   (d_req_wren),
        .d_req_mask   (d_req_mask),
        .d_resp_valid (d_resp_valid),
        .d_resp_ready (d_resp_ready),
        .d_resp_data  (d_resp_data),
        .d_resp_exc   (d_resp_exc),
        .m_addr       (m_addr),
        .m_data       (m_data),
        .m_wren       (m_wren),
        .m_mask       (m_mask),
        .m_resp       (m_resp),
        .m_exc        (m_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory environment ----------------
    function automatic logic [63:0] init_word(input logic [63:0] idx);
        return {32'hA5A5_0000 ^ idx[31:0], 32'h1234_5678 + idx[31:0]};
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return (a < 64'h0010_0000) || (a >= 64'h1000_0000 && a < 64'h1010_0000);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] mask);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    logic [63:0] ram [logic [63:0]];      // written only by DUT m_wren
    logic [63:0] ref_mem [logic [63:0]];  // written only by the reference model
    int          ram_gen = 0;

    function automatic logic [63:0] ram_read(input logic [63:0] a);
        logic [63:0] idx;
        idx = a >> 3;
        return ram.exists(idx) ? ram[idx] : init_word(idx);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] idx;
        idx = a >> 3;
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    always @(m_addr or ram_gen) m_resp = ram_read(m_addr);
    assign m_exc = !in_range(m_addr);

    // Write port: sample the request while it is stable, commit at the edge.
    initial begin
        logic        w;
        logic [63:0] wa;
        logic [63:0] wd;
        logic [7:0]  wm;
        forever begin
            @(negedge clk);
            w  = m_wren;
            wa = m_addr;
            wd = m_data;
            wm = m_mask;
            @(posedge clk);
            if (w) begin
                ram[wa >> 3] = merge(ram_read(wa), wd, wm);
                ram_gen++;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [32:0] q_i[$];   // {exc, instr}
    logic [64:0] q_d[$];   // {exc, data}
    bit          full_i = 0;
    bit          full_d = 0;
    bit          prio_d = 0;  // 1: data requester wins a tie

    // Model: evaluates each cycle after inputs and DUT outputs have settled.
    initial begin
        bit          ei, ed, gi, gd, ew;
        logic [63:0] rd;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("rst i_req_ready", i_req_ready, 0);
                check("rst d_req_ready", d_req_ready, 0);
                check("rst m_wren", m_wren, 0);
                check("rst i_resp_valid", i_resp_valid, 0);
                check("rst d_resp_valid", d_resp_valid, 0);
                full_i = 0;
                full_d = 0;
                prio_d = 0;
                q_i.delete();
                q_d.delete();
            end else begin
                check("i_resp_valid", i_resp_valid, full_i);
                check("d_resp_valid", d_resp_valid, full_d);
                ei = i_req_valid && (!full_i || i_resp_ready);
                ed = d_req_valid && (!full_d || d_resp_ready);
                gi = ei && (!ed || !prio_d);
                gd = ed && (!ei || prio_d);
                ew = gd && d_req_wren && in_range(d_req_addr);
                check("i_req_ready", i_req_ready, gi);
                check("d_req_ready", d_req_ready, gd);
                check("m_wren", m_wren, ew);
                if (gi) begin
                    rd = ref_read(i_req_addr);
                    q_i.push_back({!in_range(i_req_addr), rd[31:0]});
                    prio_d = 1;
                end
                if (gd) begin
                    rd = d_req_wren ? 64'h0 : ref_read(d_req_addr);
                    q_d.push_back({!in_range(d_req_addr), rd});
                    if (ew) ref_mem[d_req_addr >> 3] = merge(ref_read(d_req_addr), d_req_data, d_req_mask);
                    prio_d = 0;
                end
                full_i = gi || (full_i && !i_resp_ready);
                full_d = gd || (full_d && !d_resp_ready);
            end
        end
    end

    // Monitor: compares every response handshake against the scoreboard.
    initial begin
        logic [32:0] ei;
        logic [64:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (i_resp_valid && i_resp_ready) begin
                    if (q_i.size() == 0) begin
                        check("i_resp unexpected", 1, 0);
                    end else begin
                        ei = q_i.pop_front();
                        check("i_resp_instr", i_resp_instr, ei[31:0]);
                        check("i_resp_exc", i_resp_exc, ei[32]);
                    end
                end
                if (d_resp_valid && d_resp_ready) begin
                    if (q_d.size() == 0) begin
                        check("d_resp unexpected", 1, 0);
                    end else begin
                        ed = q_d.pop_front();
                        check("d_resp_data", d_resp_data, ed[63:0]);
                        check("d_resp_exc", d_resp_exc, ed[64]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic iv, input logic [63:0] ia, input logic irr,
                         input logic dv, input logic [63:0] da, input logic [63:0] dd,
                         input logic dw, input logic [7:0] dm, input logic drr);
        i_req_valid  = iv;
        i_req_addr   = ia;
        i_resp_ready = irr;
        d_req_valid  = dv;
        d_req_addr   = da;
        d_req_data   = dd;
        d_req_wren   = dw;
        d_req_mask   = dm;
        d_resp_ready = drr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 64'h0010_0000 + 64'(8 * $urandom_range(0, 3));
        return ((r % 2 == 1) ? 64'h1000_0000 : 64'h0) + 64'(8 * $urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_w;
        rst          = 1'b0;
        i_req_valid  = 0;
        i_req_addr   = 0;
        i_resp_ready = 0;
        d_req_valid  = 0;
        d_req_addr   = 0;
        d_req_data   = 0;
        d_req_wren   = 0;
        d_req_mask   = 0;
        d_resp_ready = 0;
        #1 rst = 1'b1;
        #2;
        check("reset i_resp_instr", i_resp_instr, 0);
        check("reset d_resp_data", d_resp_data, 0);
        check("reset i_resp_exc", i_resp_exc, 0);
        check("reset d_resp_exc", d_resp_exc, 0);
        check("reset m_wren", m_wren, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fetch only, address 0, consumer always ready.
        for (int k = 0; k < 4; k++) drive(1, 64'h0, 1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Contention: both request every cycle.
        for (int k = 0; k < 6; k++) drive(1, 64'(8 * k), 1, 1, rand_addr(), 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Partial store then load of the same word.
        drive(0, 0, 1, 1, 64'h1000_0008, 64'hDEAD_BEEF_0123_4567, 1, 8'h0F, 1);
        drive(0, 0, 1, 1, 64'h1000_0008, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
        exp_w = init_word(64'h1000_0008 >> 3);
        check("store merged word", ram_read(64'h1000_0008), {exp_w[63:32], 32'h0123_4567});

        // Out-of-range store must not touch memory.
        drive(0, 0, 1, 1, 64'h0010_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 8'hFF, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
        check("oor store no write", ram.exists(64'h0010_0000 >> 3), 0);

        // Backpressure on the data slot while both request.
        drive(0, 0, 1, 1, 64'h8, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(1, 64'(4 * k), 1, 1, 64'h10, 0, 0, 0, 0);
        drive(1, 64'h20, 1, 1, 64'h18, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) drive(1, 64'h24, 1, 1, 64'h20, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Reset while a store response is still held.
        drive(0, 0, 1, 1, 64'h1000_0010, 64'h1111_2222_3333_4444, 1, 8'hFF, 0);
        check("slot held before reset", d_resp_valid, 1);
        rst = 1'b1;
        #1;
        check("d_resp_valid cleared by reset", d_resp_valid, 0);
        check("no write during reset", m_wren, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(1, 64'h0, 1, 1, 64'h1000_0000, 0, 0, 0, 1);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, rand_addr(), {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0);
        end

        // Drain outstanding responses.
        for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
        check("i scoreboard empty", 128'(q_i.size()), 0);
        check("d scoreboard empty", 128'(q_d.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
